// File: rtl/fma_round_pkg.sv
// Shared types for the FMA post-normalize/round pipeline.
package fma_round_pkg;

  localparam int unsigned PKG_NE = 8;
  localparam int unsigned PKG_NF = 23;

  // RISC-V rounding-mode encoding carried on Frm.
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } frm_e;

  // Stage-1 payload: normalized significand cut down to mantissa/guard/sticky.
  // Field widths follow PKG_NE/PKG_NF, so the pipeline's NE/NF must match them.
  typedef struct packed {
    logic              sign;
    logic [PKG_NE+1:0] exp;
    logic [PKG_NF:0]   mant;
    logic              guard;
    logic              sticky;
    logic              tiny;
    logic              zero;
    frm_e              frm;
  } norm_t;

endpackage

// File: rtl/fma_round_logic.sv
// Combinational rounding, exponent adjust, overflow saturation and flags.
module fma_round_logic
  import fma_round_pkg::*;
#(
  parameter int unsigned NE = PKG_NE,
  parameter int unsigned NF = PKG_NF
) (
  input  logic           sign,
  input  logic [NE+1:0]  expo,
  input  logic [NF:0]    mant,
  input  logic           guard,
  input  logic           sticky,
  input  logic           tiny,
  input  logic           zero,
  input  logic [2:0]     frm,
  output logic [NE+NF:0] result,
  output logic           of,
  output logic           uf,
  output logic           nx
);

  localparam logic [NE+1:0] EXP_OVF = {2'b00, {NE{1'b1}}};
  localparam logic [NE+1:0] EXP_ONE = {{(NE+1){1'b0}}, 1'b1};

  logic          rup;
  logic          to_inf;
  logic [NF+1:0] mant_r;
  logic [NE+1:0] exp_r;

  // Pick increment by mode, apply it, then resolve zero and overflow cases.
  always_comb begin
    rup    = 1'b0;
    to_inf = 1'b1;
    case (frm_e'(frm))
      RNE: rup = guard & (sticky | mant[0]);
      RTZ: to_inf = 1'b0;
      RDN: begin
        rup    = sign & (guard | sticky);
        to_inf = sign;
      end
      RUP: begin
        rup    = ~sign & (guard | sticky);
        to_inf = ~sign;
      end
      RMM: rup = guard;
      default: rup = 1'b0;
    endcase

    mant_r = {1'b0, mant} + {{(NF+1){1'b0}}, rup};
    exp_r  = expo;
    // Carry out leaves mant_r = 10..0, so the fraction bits are already zero.
    if (mant_r[NF+1]) begin
      exp_r = expo + EXP_ONE;
    end else if (expo == '0 && mant_r[NF]) begin
      exp_r = EXP_ONE;
    end

    nx     = guard | sticky;
    of     = 1'b0;
    result = {sign, exp_r[NE-1:0], mant_r[NF-1:0]};

    if (zero) begin
      result = {sign, {(NE+NF){1'b0}}};
      nx     = sticky;
    end else if (!exp_r[NE+1] && exp_r >= EXP_OVF) begin
      of     = 1'b1;
      nx     = 1'b1;
      result = to_inf ? {sign, {NE{1'b1}}, {NF{1'b0}}}
                      : {sign, {(NE-1){1'b1}}, 1'b0, {NF{1'b1}}};
    end

    uf = tiny & nx;
  end

endmodule

// File: rtl/fma_round_pipe.sv
// Two-stage normalize/round pipeline for the FMA sum, valid/ready handshake.
module fma_round_pipe
  import fma_round_pkg::*;
#(
  parameter int unsigned NE     = PKG_NE,
  parameter int unsigned NF     = PKG_NF,
  parameter int unsigned FMALEN = 3*NF+6,
  parameter int unsigned SCNTW  = $clog2(FMALEN+1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FMALEN-1:0] Sm,
  input  logic [NE+1:0]     Se,
  input  logic              Ss,
  input  logic [SCNTW-1:0]  SCnt,
  input  logic              ASticky,
  input  logic [2:0]        Frm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NE+NF:0]    Result,
  output logic              OF,
  output logic              UF,
  output logic              NX
);

  localparam int unsigned KW = NE + 4;
  localparam logic [KW-1:0] K_ONE = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] K_SAT = KW'(FMALEN);

  logic                v1, v2, adv1, adv2;
  logic [NE+1:0]       ne;
  logic [KW-1:0]       k, kneg;
  logic [FMALEN-1:0]   nsh;
  logic [2*FMALEN-1:0] rext;
  logic                lost;
  norm_t               nrm, s1;
  logic [NE+NF:0]      r_res;
  logic                r_of, r_uf, r_nx;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  // Exponent after normalization and the subnormal shift, both two's complement.
  assign ne   = Se - {{(NE+2-SCNTW){1'b0}}, SCnt};
  assign k    = {{(KW-SCNTW){1'b0}}, SCnt} + {{(KW-NE-2){ne[NE+1]}}, ne} - K_ONE;
  assign kneg = -k;

  // Normalize (or denormalize when tiny) and cut into mantissa/guard/sticky.
  always_comb begin
    nrm      = '0;
    nrm.sign = Ss;
    nrm.frm  = frm_e'(Frm);
    nsh      = '0;
    rext     = '0;
    lost     = 1'b0;
    if (Sm == '0) begin
      nrm.zero = 1'b1;
    end else if (!ne[NE+1] && ne != '0) begin
      nsh     = Sm << SCnt;
      nrm.exp = ne;
    end else begin
      nrm.tiny = 1'b1;
      if (!k[KW-1]) begin
        nsh = Sm << k;
      end else begin
        // Right shift through a double-width window keeps the dropped bits for sticky.
        rext = {Sm, {FMALEN{1'b0}}} >> ((kneg > K_SAT) ? K_SAT : kneg);
        nsh  = rext[2*FMALEN-1:FMALEN];
        lost = |rext[FMALEN-1:0];
      end
    end
    nrm.mant   = nsh[FMALEN-1 -: NF+1];
    nrm.guard  = nsh[FMALEN-NF-2];
    nrm.sticky = (|nsh[FMALEN-NF-3:0]) | lost | ASticky;
  end

  // Stage 1 register: captures a beat whenever the stage can advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) s1 <= nrm;
    end
  end

  fma_round_logic #(.NE(NE), .NF(NF)) u_round (
    .sign   (s1.sign),
    .expo   (s1.exp),
    .mant   (s1.mant),
    .guard  (s1.guard),
    .sticky (s1.sticky),
    .tiny   (s1.tiny),
    .zero   (s1.zero),
    .frm    (s1.frm),
    .result (r_res),
    .of     (r_of),
    .uf     (r_uf),
    .nx     (r_nx)
  );

  // Stage 2 register: result and flags only change when a new beat loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2     <= 1'b0;
      Result <= '0;
      OF     <= 1'b0;
      UF     <= 1'b0;
      NX     <= 1'b0;
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        Result <= r_res;
        OF     <= r_of;
        UF     <= r_uf;
        NX     <= r_nx;
      end
    end
  end

endmodule

// File: tb/tb_fma_round_pipe.sv
// Bench for fma_round_pipe: directed vectors, handshake corner cases, random traffic.
module tb_fma_round_pipe;
  import fma_round_pkg::*;

  localparam int unsigned NE     = 8;
  localparam int unsigned NF     = 23;
  localparam int unsigned FMALEN = 75;
  localparam int unsigned SCNTW  = 7;

  logic              clk = 1'b0;
  logic              reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [FMALEN-1:0] Sm;
  logic [NE+1:0]     Se;
  logic              Ss, ASticky;
  logic [SCNTW-1:0]  SCnt;
  logic [2:0]        Frm;
  logic [NE+NF:0]    Result;
  logic              OF, UF, NX;

  fma_round_pipe #(.NE(NE), .NF(NF), .FMALEN(FMALEN), .SCNTW(SCNTW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Sm(Sm), .Se(Se), .Ss(Ss), .SCnt(SCnt), .ASticky(ASticky), .Frm(Frm),
    .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .OF(OF), .UF(UF), .NX(NX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [74:0] sm;
    logic [9:0]  se;
    logic        ss;
    logic [6:0]  scnt;
    logic        ast;
    logic [2:0]  frm;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  vec_t        vecs[$];
  logic [34:0] expq[$];
  logic [34:0] cur_exp;
  logic [34:0] stall_val;
  logic        stall_seen;
  logic        last_acc;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Reference: exact remainder against half-ULP, no guard/sticky bookkeeping.
  function automatic logic [34:0] model(input logic [74:0] sm, input logic [9:0] se,
                                        input logic ss, input logic [6:0] scnt,
                                        input logic ast, input logic [2:0] frm);
    logic [159:0] n, m, rem, half;
    int           ne, sh, e;
    logic         tiny, inexact, above, at_half, up, to_inf;
    if (sm == '0) return {ss, 31'd0, 2'b00, ast};
    ne      = int'($signed(se)) - int'(scnt);
    n       = 160'(sm) << scnt;
    tiny    = (ne < 1);
    sh      = tiny ? 52 - ne : 51;
    if (sh > 150) sh = 150;
    m       = n >> sh;
    rem     = n - (m << sh);
    half    = 160'(1) << (sh - 1);
    inexact = (rem != '0) || ast;
    above   = (rem > half) || (rem == half && ast);
    at_half = (rem == half) && !ast;
    case (frm)
      3'd0:    up = above || (at_half && m[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = ss && inexact;
      3'd3:    up = !ss && inexact;
      default: up = above || at_half;
    endcase
    m = m + 160'(up);
    e = tiny ? 0 : ne;
    if (m == (160'(1) << 24)) begin
      m = 160'(1) << 23;
      e++;
    end
    if (tiny && m >= (160'(1) << 23)) e = 1;
    if (e >= 255) begin
      to_inf = (frm == 3'd0) || (frm == 3'd4) || (frm == 3'd2 && ss) || (frm == 3'd3 && !ss);
      return {(to_inf ? {ss, 8'hFF, 23'd0} : {ss, 8'hFE, 23'h7FFFFF}), 3'b101};
    end
    return {ss, 8'(e), m[22:0], 1'b0, tiny && inexact, inexact};
  endfunction

  function automatic vec_t mk(input logic [74:0] sm, input logic [9:0] se, input logic ss,
                              input logic [6:0] scnt, input logic ast, input logic [2:0] frm,
                              input logic [31:0] res, input logic [2:0] fl);
    vec_t v;
    v.sm = sm; v.se = se; v.ss = ss; v.scnt = scnt; v.ast = ast; v.frm = frm;
    v.res = res; v.fl = fl;
    return v;
  endfunction

  task automatic set_in(input logic v, input logic [74:0] sm, input logic [9:0] se,
                        input logic ss, input logic [6:0] scnt, input logic ast,
                        input logic [2:0] frm, input logic [34:0] e);
    in_valid = v; Sm = sm; Se = se; Ss = ss; SCnt = scnt; ASticky = ast; Frm = frm;
    cur_exp  = e;
  endtask

  task automatic set_vec(input vec_t v);
    set_in(1'b1, v.sm, v.se, v.ss, v.scnt, v.ast, v.frm, {v.res, v.fl});
  endtask

  task automatic rand_beat(input logic v);
    logic [95:0] r96;
    logic [74:0] sm;
    logic [6:0]  sc;
    logic [9:0]  se;
    logic [2:0]  fr;
    logic        ss, ast;
    int          p, nt;
    r96 = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 31) == 0) begin
      sm = '0;
      sc = 7'($urandom_range(0, 74));
    end else begin
      p  = int'($urandom_range(0, 74));
      sm = (r96[74:0] & ((75'(1) << p) - 75'(1))) | (75'(1) << p);
      sc = 7'(74 - p);
    end
    case ($urandom_range(0, 3))
      0:       nt = int'($urandom_range(1, 254));
      1:       nt = 240 + int'($urandom_range(0, 30));
      2:       nt = -30 + int'($urandom_range(0, 35));
      default: nt = -200 + int'($urandom_range(0, 550));
    endcase
    se  = 10'(nt + int'(sc));
    ss  = 1'($urandom);
    ast = ($urandom_range(0, 3) == 0);
    fr  = 3'($urandom_range(0, 4));
    set_in(v, sm, se, ss, sc, ast, fr, model(sm, se, ss, sc, ast, fr));
  endtask

  // One clock: handshakes sampled at negedge, inputs may change at posedge+1.
  task automatic cycle();
    @(negedge clk);
    if (stall_seen)
      check("stall_hold", 40'({out_valid, Result, OF, UF, NX}), 40'({1'b1, stall_val}));
    last_acc = in_valid && in_ready && !flush && reset_n;
    if (last_acc) expq.push_back(cur_exp);
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h, want no output", {Result, OF, UF, NX});
      end else begin
        check("result", 40'({Result, OF, UF, NX}), 40'(expq.pop_front()));
      end
    end
    stall_seen = out_valid && !out_ready && !flush;
    stall_val  = {Result, OF, UF, NX};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [74:0] top, g50, ones25;
    int          n;
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1; stall_seen = 1'b0; last_acc = 1'b0;
    set_in(1'b0, '0, '0, 1'b0, '0, 1'b0, 3'd0, '0);
    #12;
    check("reset_state", 40'({out_valid, Result, OF, UF, NX, in_ready}), 40'(1));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    top    = 75'(1) << 74;
    g50    = 75'(1) << 50;
    ones25 = {25'h1FFFFFF, 50'd0};
    vecs.push_back(mk(top,              10'd127, 0, 0, 0, RNE, 32'h3F800000, 3'b000));
    vecs.push_back(mk(top | g50,        10'd127, 0, 0, 0, RNE, 32'h3F800000, 3'b001));
    vecs.push_back(mk(top | g50,        10'd127, 0, 0, 0, RUP, 32'h3F800001, 3'b001));
    vecs.push_back(mk(top,              10'd255, 0, 0, 0, RNE, 32'h7F800000, 3'b101));
    vecs.push_back(mk(top,              10'd255, 0, 0, 0, RTZ, 32'h7F7FFFFF, 3'b101));
    vecs.push_back(mk(top,              10'd0,   0, 0, 0, RNE, 32'h00400000, 3'b000));
    vecs.push_back(mk(top | 75'(1),     10'd0,   0, 0, 0, RNE, 32'h00400000, 3'b011));
    vecs.push_back(mk(ones25,           10'd127, 0, 0, 0, RNE, 32'h40000000, 3'b001));
    vecs.push_back(mk(ones25,           10'd0,   0, 0, 0, RNE, 32'h00800000, 3'b011));
    vecs.push_back(mk(top | g50,        10'd127, 1, 0, 0, RDN, 32'hBF800001, 3'b001));
    vecs.push_back(mk(top,              10'd255, 0, 0, 0, RDN, 32'h7F7FFFFF, 3'b101));
    vecs.push_back(mk(top,              10'd255, 1, 0, 0, RUP, 32'hFF7FFFFF, 3'b101));
    vecs.push_back(mk('0,               10'd50,  1, 3, 1, RUP, 32'h80000000, 3'b001));
    vecs.push_back(mk(top | g50,        10'd127, 0, 0, 0, RMM, 32'h3F800001, 3'b001));
    vecs.push_back(mk(top | g50 | 75'(1), 10'd127, 0, 0, 0, RTZ, 32'h3F800000, 3'b001));

    // Two-cycle latency on an idle pipe.
    set_vec(vecs[0]);
    cycle();
    check("latency_c1", 40'(out_valid), 40'(0));
    in_valid = 1'b0;
    cycle();
    check("latency_c2", 40'(out_valid), 40'(1));
    cycle();

    // Directed table, back to back.
    foreach (vecs[i]) begin
      set_vec(vecs[i]);
      cycle();
    end
    in_valid = 1'b0;
    repeat (4) cycle();

    // Backpressure: four beats while the consumer stalls for four cycles.
    out_ready = 1'b0;
    n = 0;
    rand_beat(1'b1);
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (c == 4) out_ready = 1'b1;
      cycle();
      if (last_acc) begin
        n++;
        if (n < 4) rand_beat(1'b1);
        else in_valid = 1'b0;
      end
      if (c == 1) check("bp_in_ready_low", 40'(in_ready), 40'(0));
    end
    check("bp_all_accepted", 40'(n), 40'(4));
    repeat (6) cycle();

    // Asynchronous reset mid-stream.
    set_vec(vecs[0]);
    cycle();
    set_vec(vecs[1]);
    cycle();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_reset", 40'({out_valid, Result, OF, UF, NX}), 40'(0));
    expq.delete();
    stall_seen = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush with both stages full, then a fresh beat.
    out_ready = 1'b0;
    set_vec(vecs[2]);
    cycle();
    set_vec(vecs[3]);
    cycle();
    flush = 1'b1;
    set_vec(vecs[4]);
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expq.delete();
    check("flush_clear", 40'(out_valid), 40'(0));
    repeat (2) cycle();
    set_vec(vecs[5]);
    cycle();
    check("flush_lat_c1", 40'(out_valid), 40'(0));
    in_valid = 1'b0;
    cycle();
    check("flush_lat_c2", 40'(out_valid), 40'(1));
    cycle();

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      rand_beat($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && expq.size() > 0; c++) cycle();
    check("drain_empty", 40'(expq.size()), 40'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
